nmr_bstrm_pls_gen: RTL

- Bitstream pulse generator; the responder side of the BT_START/BT_DONE command handshake driven by the NMR bitstream sequencer.
- Accepts one command, {initial delay, pulse length, post-pulse delay}, and plays it out on a single pulse line.
- Reports idle/ready on BT_DONE so the sequencer can issue the next command.
- Sits between the sequencer and the NMR TX gating logic.

---
 rtl/nmr_bstrm_pls_gen.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/nmr_bstrm_pls_gen.sv
// Bitstream pulse generator: the responder side of the BT_START/BT_DONE
// handshake. It takes one {initial delay, pulse length, post-pulse delay}
// command and plays it out on PLS_OUT. It counts completed commands on CMD_CNT.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready, BT_DONE=1, waiting for BT_START
// LOAD  | one cycle; picks the first nonzero phase and loads the timer
// IDLY  | initial delay, PLS_OUT inactive
// PLS   | pulse, PLS_OUT = PLS_POL
// EDLY  | post-pulse delay, PLS_OUT inactive
module nmr_bstrm_pls_gen #(
  parameter int   IDLY_WIDTH = 32,
  parameter int   PLS_WIDTH  = 32,
  parameter int   EDLY_WIDTH = 32,
  parameter logic PLS_POL    = 1'b1,
  parameter int   CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BT_START,
  output logic                  BT_DONE,
  input  logic [IDLY_WIDTH-1:0] idly_reg,
  input  logic [PLS_WIDTH-1:0]  pls_reg,
  input  logic [EDLY_WIDTH-1:0] edly_reg,
  output logic                  PLS_OUT,
  output logic [CNT_WIDTH-1:0]  CMD_CNT,
  input  logic                  CNT_CLR
);

  // The timer must hold the widest field so an all-ones value runs its full length.
  localparam int CW_A = (IDLY_WIDTH > PLS_WIDTH) ? IDLY_WIDTH : PLS_WIDTH;
  localparam int CW   = (CW_A > EDLY_WIDTH) ? CW_A : EDLY_WIDTH;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_LOAD = 5'b00010,
    ST_IDLY = 5'b00100,
    ST_PLS  = 5'b01000,
    ST_EDLY = 5'b10000
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IDLY_WIDTH-1:0] idly_q;
  logic [PLS_WIDTH-1:0]  pls_q;
  logic [EDLY_WIDTH-1:0] edly_q;
  logic                  done_q;
  logic                  pls_out_q;
  logic [CNT_WIDTH-1:0]  cmd_cnt_q;
  logic                  latch_en;
  logic                  cmd_done;

  // Next nonzero phase, searching from each phase onward; zero phases are skipped.
  state_e        from_idly_st, from_pls_st, from_edly_st;
  logic [CW-1:0] from_idly_cnt, from_pls_cnt, from_edly_cnt;

  // Resolve the phase chain from the latched command fields.
  always_comb begin
    from_edly_st  = ST_IDLE;
    from_edly_cnt = '0;
    if (edly_q != '0) begin
      from_edly_st  = ST_EDLY;
      from_edly_cnt = CW'(edly_q);
    end
    from_pls_st  = from_edly_st;
    from_pls_cnt = from_edly_cnt;
    if (pls_q != '0) begin
      from_pls_st  = ST_PLS;
      from_pls_cnt = CW'(pls_q);
    end
    from_idly_st  = from_pls_st;
    from_idly_cnt = from_pls_cnt;
    if (idly_q != '0) begin
      from_idly_st  = ST_IDLY;
      from_idly_cnt = CW'(idly_q);
    end
  end

  // Next-state and timer logic; a phase ends when the down-counter reaches 1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (BT_START) begin
          state_d  = ST_LOAD;
          latch_en = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = from_idly_st;
        cnt_d   = from_idly_cnt;
      end
      ST_IDLY: begin
        if (cnt_q == CW'(1)) begin
          state_d = from_pls_st;
          cnt_d   = from_pls_cnt;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_PLS: begin
        if (cnt_q == CW'(1)) begin
          state_d = from_edly_st;
          cnt_d   = from_edly_cnt;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_EDLY: begin
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    cmd_done = (state_q != ST_IDLE) && (state_d == ST_IDLE);
  end

  // FSM registers; outputs are decoded from the next state so they change on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idly_q    <= '0;
      pls_q     <= '0;
      edly_q    <= '0;
      done_q    <= 1'b1;
      pls_out_q <= ~PLS_POL;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= (state_d == ST_IDLE);
      pls_out_q <= (state_d == ST_PLS) ? PLS_POL : ~PLS_POL;
      if (latch_en) begin
        idly_q <= idly_reg;
        pls_q  <= pls_reg;
        edly_q <= edly_reg;
      end
    end
  end

  // Completed-command counter; clear wins over a coincident completion.
  always_ff @(posedge CLK) begin
    if (RST || CNT_CLR) begin
      cmd_cnt_q <= '0;
    end else if (cmd_done) begin
      cmd_cnt_q <= cmd_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign BT_DONE = done_q;
  assign PLS_OUT = pls_out_q;
  assign CMD_CNT = cmd_cnt_q;

endmodule
